tlc_multi_phase: RTL and testbench

Parametrised traffic-light controller serving `N_PH` conflicting approaches in round-robin order. Each phase runs green, yellow and all-red clearance. Phases with no pending demand are skipped, and green rests on the current phase when nobody else is waiting. It is driven by a slow tick strobe and exports per-phase lamp codes plus a countdown of remaining ticks for the display driver.

---
 rtl/tlc_pkg.sv | 24 ++
 rtl/tlc_multi_phase_if.sv | 37 +++
 rtl/tlc_rr_pick.sv | 34 +++
 rtl/tlc_multi_phase.sv | 127 ++++++++++++
 tb/tb_tlc_multi_phase.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// tlc_pkg : lamp colour codes, controller state encoding, duration check
// Rev 1.0
// ============================================================================
package tlc_pkg;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } tlc_state_e;

  // A duration must be loadable into the CW-bit down-counter and be non-zero.
  function automatic bit dur_ok(input int t, input int cw);
    return (t >= 1) && (t <= ((1 << cw) - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_multi_phase_if.sv
`default_nettype none
// ============================================================================
// tlc_multi_phase_if : tick/request inputs and lamp/status outputs of the TLC
// Rev 1.0
// ============================================================================
interface tlc_multi_phase_if #(
  parameter int N_PH = 4,
  parameter int CW   = 4
);
  localparam int PW = $clog2(N_PH);

  logic              tick;
  logic [N_PH-1:0]   req;
  logic [2*N_PH-1:0] lamp;
  logic [PW-1:0]     phase;
  logic [CW-1:0]     remaining;
  logic              cycle_done;

  modport master (
    output tick,
    output req,
    input  lamp,
    input  phase,
    input  remaining,
    input  cycle_done
  );

  modport slave (
    input  tick,
    input  req,
    output lamp,
    output phase,
    output remaining,
    output cycle_done
  );
endinterface
`default_nettype wire

// File: rtl/tlc_rr_pick.sv
`default_nettype none
// ============================================================================
// tlc_rr_pick : circular priority picker, first requester after phase_i
// Rev 1.0
// ============================================================================
module tlc_rr_pick #(
  parameter  int N_PH = 4,
  localparam int PW   = $clog2(N_PH)
) (
  input  logic [N_PH-1:0] req_i,
  input  logic [PW-1:0]   phase_i,
  output logic [PW-1:0]   nxt_o,
  output logic            valid_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester wins;
  // offset 0 (the current phase) is never examined.
  always_comb begin
    nxt_o   = phase_i;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = N_PH - 1; k >= 1; k--) begin
      idx = (int'(phase_i) + k) % N_PH;
      if (req_i[idx[PW-1:0]]) begin
        nxt_o   = idx[PW-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlc_multi_phase.sv
`default_nettype none
// ============================================================================
// tlc_multi_phase : round-robin multi-phase traffic-light controller
// Rev 1.0
// ============================================================================
module tlc_multi_phase #(
  parameter int N_PH  = 4,
  parameter int CW    = 4,
  parameter int T_GRN = 5,
  parameter int T_YEL = 2,
  parameter int T_AR  = 1
) (
  input logic              clk,
  input logic              rst,
  tlc_multi_phase_if.slave bus
);
  import tlc_pkg::*;

  localparam int PW = $clog2(N_PH);
  localparam logic [CW-1:0]     C_T_GRN    = CW'(T_GRN);
  localparam logic [CW-1:0]     C_T_YEL    = CW'(T_YEL);
  localparam logic [CW-1:0]     C_T_AR     = CW'(T_AR);
  localparam logic [2*N_PH-1:0] C_LAMP_RST = {{(2*N_PH-2){1'b0}}, GRN};

  generate
    if (N_PH < 2 || N_PH > 16) begin : g_bad_nph
      $error("tlc_multi_phase: N_PH must be in 2..16");
    end
    if (!dur_ok(T_GRN, CW) || !dur_ok(T_YEL, CW) || !dur_ok(T_AR, CW)) begin : g_bad_dur
      $error("tlc_multi_phase: durations must lie in 1..2**CW-1");
    end
  endgenerate

  tlc_state_e        state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [PW-1:0]     nxt_ph_q, nxt_ph_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [2*N_PH-1:0] lamp_q, lamp_d;
  logic              cdone_q, cdone_d;
  logic [PW-1:0]     pick_nxt;
  logic              pick_valid;

  tlc_rr_pick #(.N_PH(N_PH)) u_pick (
    .req_i   (bus.req),
    .phase_i (phase_q),
    .nxt_o   (pick_nxt),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GREEN;
      phase_q  <= '0;
      nxt_ph_q <= '0;
      rem_q    <= C_T_GRN;
      lamp_q   <= C_LAMP_RST;
      cdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      nxt_ph_q <= nxt_ph_d;
      rem_q    <= rem_d;
      lamp_q   <= lamp_d;
      cdone_q  <= cdone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    nxt_ph_d = nxt_ph_q;
    rem_d    = rem_q;
    cdone_d  = 1'b0;
    lamp_d   = '0;

    if (bus.tick) begin
      if (rem_q > CW'(1)) begin
        rem_d = rem_q - CW'(1);
      end else begin
        case (state_q)
          GREEN: begin
            // No other requester: keep green and start a fresh green interval.
            if (pick_valid) begin
              nxt_ph_d = pick_nxt;
              state_d  = YELLOW;
              rem_d    = C_T_YEL;
            end else begin
              rem_d    = C_T_GRN;
            end
          end
          YELLOW: begin
            state_d = ALLRED;
            rem_d   = C_T_AR;
          end
          ALLRED: begin
            phase_d = nxt_ph_q;
            state_d = GREEN;
            rem_d   = C_T_GRN;
            cdone_d = (nxt_ph_q <= phase_q);
          end
          default: begin
            state_d = GREEN;
            rem_d   = C_T_GRN;
          end
        endcase
      end
    end

    // Lamps are decoded from the next state so they change with the state.
    for (int i = 0; i < N_PH; i++) begin
      if (phase_d == PW'(i)) begin
        if (state_d == GREEN) begin
          lamp_d[2*i +: 2] = GRN;
        end else if (state_d == YELLOW) begin
          lamp_d[2*i +: 2] = YEL;
        end
      end
    end
  end

  assign bus.lamp       = lamp_q;
  assign bus.phase      = phase_q;
  assign bus.remaining  = rem_q;
  assign bus.cycle_done = cdone_q;

endmodule
`default_nettype wire

// File: tb/tb_tlc_multi_phase.sv
`default_nettype none
// ============================================================================
// tb_tlc_multi_phase : randomized self-checking bench with a timeline model
// Rev 1.0
// ============================================================================
module tb_tlc_multi_phase;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  tlc_multi_phase_if #(.N_PH(4), .CW(4)) bus_a ();
  tlc_multi_phase_if #(.N_PH(3), .CW(3)) bus_b ();

  tlc_multi_phase #(.N_PH(4), .CW(4), .T_GRN(5), .T_YEL(2), .T_AR(1)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  tlc_multi_phase #(.N_PH(3), .CW(3), .T_GRN(7), .T_YEL(1), .T_AR(2)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  // Model: per DUT, interval kind (0 green, 1 yellow, 2 all-red), ticks elapsed
  // in it, the lit phase and the phase chosen to run next.
  int p_n  [2] = '{4, 3};
  int p_tg [2] = '{5, 7};
  int p_ty [2] = '{2, 1};
  int p_ta [2] = '{1, 2};
  int m_kind [2];
  int m_el   [2];
  int m_ph   [2];
  int m_tgt  [2];
  bit m_cd   [2];

  function automatic int dur(input int id, input int kind);
    if (kind == 0) return p_tg[id];
    if (kind == 1) return p_ty[id];
    return p_ta[id];
  endfunction

  function automatic int m_rem(input int id);
    return dur(id, m_kind[id]) - m_el[id];
  endfunction

  function automatic int m_lamp(input int id);
    if (m_kind[id] == 2) return 0;
    return ((m_kind[id] == 0) ? 2 : 1) << (2 * m_ph[id]);
  endfunction

  function automatic logic [14:0] exp_a();
    return {8'(m_lamp(0)), 2'(m_ph[0]), 4'(m_rem(0)), m_cd[0]};
  endfunction

  function automatic logic [11:0] exp_b();
    return {6'(m_lamp(1)), 2'(m_ph[1]), 3'(m_rem(1)), m_cd[1]};
  endfunction

  wire [14:0] obs_a = {bus_a.lamp, bus_a.phase, bus_a.remaining, bus_a.cycle_done};
  wire [11:0] obs_b = {bus_b.lamp, bus_b.phase, bus_b.remaining, bus_b.cycle_done};

  task automatic model_step(input int id, input bit r, input bit t, input int q);
    bit found;
    m_cd[id] = 1'b0;
    if (r) begin
      m_kind[id] = 0; m_el[id] = 0; m_ph[id] = 0; m_tgt[id] = 0;
    end else if (t) begin
      m_el[id]++;
      if (m_el[id] == dur(id, m_kind[id])) begin
        m_el[id] = 0;
        if (m_kind[id] == 0) begin
          found = 1'b0;
          for (int j = 1; j < p_n[id]; j++) begin
            if (!found && q[(m_ph[id] + j) % p_n[id]]) begin
              m_tgt[id] = (m_ph[id] + j) % p_n[id];
              found = 1'b1;
            end
          end
          if (found) m_kind[id] = 1;
        end else if (m_kind[id] == 1) begin
          m_kind[id] = 2;
        end else begin
          m_cd[id]   = (m_tgt[id] <= m_ph[id]);
          m_ph[id]   = m_tgt[id];
          m_kind[id] = 0;
        end
      end
    end
  endtask

  task automatic cyc_a(input bit r, input bit t, input logic [3:0] q);
    @(negedge clk);
    rst_a = r; bus_a.tick = t; bus_a.req = q;
    @(posedge clk);
    model_step(0, r, t, int'(q));
    #1;
  endtask

  task automatic cyc_b(input bit r, input bit t, input logic [2:0] q);
    @(negedge clk);
    rst_b = r; bus_b.tick = t; bus_b.req = q;
    @(posedge clk);
    model_step(1, r, t, int'(q));
    #1;
  endtask

  // No two approaches may be non-red at once, and code 11 never appears.
  always @(negedge clk) begin
    int nz_a;
    int nz_b;
    bit bad;
    if (mon_en) begin
      nz_a = 0; nz_b = 0; bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (bus_a.lamp[2*i +: 2] !== 2'b00) nz_a++;
        if (bus_a.lamp[2*i +: 2] === 2'b11) bad = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (bus_b.lamp[2*i +: 2] !== 2'b00) nz_b++;
        if (bus_b.lamp[2*i +: 2] === 2'b11) bad = 1'b1;
      end
      n_total++;
      if (nz_a > 1 || nz_b > 1 || bad)
        $display("FAIL lamp_exclusive t=%0t: lamp_a=%b lamp_b=%b, need at most one non-red field and no 11",
                 $time, bus_a.lamp, bus_b.lamp);
      else n_pass++;
    end
  end

  task automatic test_reset();
    rst_b = 1'b1; bus_b.tick = 1'b0; bus_b.req = '0;
    cyc_a(1'b1, 1'b0, 4'h0);
    cyc_a(1'b1, 1'b1, 4'hF);
    n_total++;
    if (obs_a !== {8'b0000_0010, 2'd0, 4'd5, 1'b0})
      $display("FAIL reset_a: got %h expected %h", obs_a, {8'b0000_0010, 2'd0, 4'd5, 1'b0});
    else n_pass++;
    n_total++;
    if (obs_b !== {6'b00_0010, 2'd0, 3'd7, 1'b0})
      $display("FAIL reset_b: got %h expected %h", obs_b, {6'b00_0010, 2'd0, 3'd7, 1'b0});
    else n_pass++;
    rst_b = 1'b0;
    model_step(1, 1'b1, 1'b0, 0);
    mon_en = 1'b1;
  endtask

  task automatic test_all_req();
    int grn = 0, yel = 0, ar = 0, cd = 0, seq, last;
    cyc_a(1'b1, 1'b0, 4'hF);
    last = int'(bus_a.phase);
    seq  = last + 1;
    for (int c = 1; c <= 32; c++) begin
      cyc_a(1'b0, 1'b1, 4'hF);
      n_total++;
      if (obs_a !== exp_a()) $display("FAIL all_req cyc %0d: got %h expected %h", c, obs_a, exp_a());
      else n_pass++;
      if (bus_a.lamp == 8'h00) ar++;
      for (int i = 0; i < 4; i++) begin
        if (bus_a.lamp[2*i +: 2] == 2'b10) grn++;
        if (bus_a.lamp[2*i +: 2] == 2'b01) yel++;
      end
      if (bus_a.cycle_done) cd++;
      if (int'(bus_a.phase) != last) begin
        last = int'(bus_a.phase);
        seq  = (seq << 4) | (last + 1);
      end
    end
    n_total++;
    if ({grn, yel, ar} !== {32'd20, 32'd8, 32'd4})
      $display("FAIL all_req_colours: got grn=%0d yel=%0d ar=%0d expected 20/8/4", grn, yel, ar);
    else n_pass++;
    n_total++;
    if (cd !== 1 || bus_a.cycle_done !== 1'b1)
      $display("FAIL all_req_cycle_done: got %0d pulses (last=%b) expected 1 on the final edge", cd, bus_a.cycle_done);
    else n_pass++;
    n_total++;
    if (seq !== 32'h12341) $display("FAIL all_req_sequence: got %h expected 12341 (phase+1 digits)", seq);
    else n_pass++;
  endtask

  task automatic test_no_req();
    int reloads = 0;
    cyc_a(1'b1, 1'b0, 4'h0);
    for (int c = 1; c <= 20; c++) begin
      cyc_a(1'b0, 1'b1, 4'h0);
      n_total++;
      if (obs_a !== exp_a()) $display("FAIL no_req cyc %0d: got %h expected %h", c, obs_a, exp_a());
      else n_pass++;
      if (bus_a.remaining == 4'd5) reloads++;
    end
    n_total++;
    if (reloads !== 4 || bus_a.lamp !== 8'b0000_0010)
      $display("FAIL no_req_rest: got reloads=%0d lamp=%b expected 4 and 00000010", reloads, bus_a.lamp);
    else n_pass++;
  endtask

  task automatic test_single_req();
    logic [1:0] lit13 = 2'b00;
    cyc_a(1'b1, 1'b0, 4'b0100);
    for (int c = 1; c <= 16; c++) begin
      cyc_a(1'b0, 1'b1, 4'b0100);
      n_total++;
      if (obs_a !== exp_a()) $display("FAIL single_req cyc %0d: got %h expected %h", c, obs_a, exp_a());
      else n_pass++;
      lit13 = lit13 | bus_a.lamp[3:2] | bus_a.lamp[7:6];
    end
    n_total++;
    if ({lit13, bus_a.phase, bus_a.lamp} !== {2'b00, 2'd2, 8'b0010_0000})
      $display("FAIL single_req_final: got lit13=%b phase=%0d lamp=%b expected 00/2/00100000",
               lit13, bus_a.phase, bus_a.lamp);
    else n_pass++;
  endtask

  task automatic test_skip_hold();
    cyc_a(1'b1, 1'b0, 4'h0);
    for (int c = 1; c <= 18; c++) begin
      cyc_a(1'b0, 1'b1, (c == 5) ? 4'b1000 : 4'b0000);
      n_total++;
      if (obs_a !== exp_a()) $display("FAIL skip_hold cyc %0d: got %h expected %h", c, obs_a, exp_a());
      else n_pass++;
      if (c == 8) begin
        n_total++;
        if ({bus_a.lamp, bus_a.phase, bus_a.remaining} !== {8'b1000_0000, 2'd3, 4'd5})
          $display("FAIL skip_hold_entry: got lamp=%b phase=%0d rem=%0d expected 10000000/3/5",
                   bus_a.lamp, bus_a.phase, bus_a.remaining);
        else n_pass++;
      end
    end
    n_total++;
    if ({bus_a.lamp, bus_a.phase} !== {8'b1000_0000, 2'd3})
      $display("FAIL skip_hold_rest: got lamp=%b phase=%0d expected 10000000/3", bus_a.lamp, bus_a.phase);
    else n_pass++;
  endtask

  task automatic test_stall_reset();
    cyc_a(1'b1, 1'b0, 4'hF);
    for (int c = 1; c <= 5; c++) cyc_a(1'b0, 1'b1, 4'hF);
    for (int c = 1; c <= 20; c++) begin
      cyc_a(1'b0, 1'b0, 4'($urandom));
      n_total++;
      if (obs_a !== exp_a() || m_kind[0] != 1)
        $display("FAIL stall cyc %0d: got %h expected %h (yellow held)", c, obs_a, exp_a());
      else n_pass++;
    end
    cyc_a(1'b1, 1'b1, 4'hF);
    n_total++;
    if (obs_a !== {8'b0000_0010, 2'd0, 4'd5, 1'b0})
      $display("FAIL stall_reset: got %h expected %h", obs_a, {8'b0000_0010, 2'd0, 4'd5, 1'b0});
    else n_pass++;
  endtask

  task automatic test_random();
    bit r, t;
    cyc_a(1'b1, 1'b0, 4'h0);
    for (int c = 1; c <= 400; c++) begin
      r = ($urandom_range(0, 99) == 0);
      t = ($urandom_range(0, 3) != 0);
      cyc_a(r, t, 4'($urandom & $urandom));
      n_total++;
      if (obs_a !== exp_a()) $display("FAIL random cyc %0d: got %h expected %h", c, obs_a, exp_a());
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    int mx = 0, cd = 0;
    cyc_b(1'b1, 1'b0, 3'b111);
    for (int c = 1; c <= 60; c++) begin
      cyc_b(1'b0, 1'b1, 3'b111);
      n_total++;
      if (obs_b !== exp_b()) $display("FAIL sweep cyc %0d: got %h expected %h", c, obs_b, exp_b());
      else n_pass++;
      if (int'(bus_b.remaining) > mx) mx = int'(bus_b.remaining);
      if (bus_b.cycle_done) cd++;
    end
    n_total++;
    if (mx !== 7 || cd !== 2)
      $display("FAIL sweep_peak: got max_rem=%0d cycle_done=%0d expected 7 and 2", mx, cd);
    else n_pass++;
    for (int c = 1; c <= 150; c++) begin
      cyc_b(1'b0, ($urandom_range(0, 2) != 0), 3'($urandom));
      n_total++;
      if (obs_b !== exp_b()) $display("FAIL sweep_random cyc %0d: got %h expected %h", c, obs_b, exp_b());
      else n_pass++;
    end
  endtask

  initial begin
    rst_a = 1'b1; bus_a.tick = 1'b0; bus_a.req = '0;
    rst_b = 1'b1; bus_b.tick = 1'b0; bus_b.req = '0;
    test_reset();
    test_all_req();
    test_no_req();
    test_single_req();
    test_skip_hold();
    test_stall_reset();
    test_random();
    bus_a.tick = 1'b0;
    test_sweep();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
